// File: rtl/mem_stage_pkg.sv
// Shared encodings for the load/store stage: opcodes, access sizes, FSM states
// and the alignment rule used both at issue time and in the datapath.
package mem_stage_pkg;

    localparam int DATA_W = 64;

    localparam logic [4:0] OPCODE_LB = 5'b00000;
    localparam logic [4:0] OPCODE_SB = 5'b01000;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_REQ   = 2'd1,
        MEM_DONE  = 2'd2,
        MEM_FAULT = 2'd3
    } mem_state_e;

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            MEM_SIZE_H: return lo[0];
            MEM_SIZE_W: return |lo[1:0];
            MEM_SIZE_D: return |lo;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/acknowledge port. The stage drives the master side; the
// RAM (or a testbench model) drives the slave side.
interface mem_stage_if
    import mem_stage_pkg::*;
();
    logic              ram_req;
    logic              ram_we;
    logic [DATA_W-1:0] ram_addr;
    logic [7:0]        ram_wmask;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wmask, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wmask, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Byte-lane alignment: store mask/shift toward the RAM and load shift plus
// truncation and sign/zero extension back to a 64-bit register value.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              zext,
    input  logic [2:0]        offset,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [7:0]        wmask,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_result
);

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz,
                                                 input logic z);
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [31:0]       w;
        logic signed [DATA_W-1:0] s;
        logic [DATA_W-1:0]        keep;
        b = v[7:0];
        h = v[15:0];
        w = v[31:0];
        case (sz)
            MEM_SIZE_B: begin s = DATA_W'(b); keep = 64'h0000_0000_0000_00FF; end
            MEM_SIZE_H: begin s = DATA_W'(h); keep = 64'h0000_0000_0000_FFFF; end
            MEM_SIZE_W: begin s = DATA_W'(w); keep = 64'h0000_0000_FFFF_FFFF; end
            default:    begin s = v;          keep = '1;                      end
        endcase
        return z ? (v & keep) : s;
    endfunction

    logic [7:0]        base_mask;
    logic [DATA_W-1:0] ld_shift;

    always_comb begin
        case (size)
            MEM_SIZE_B: base_mask = 8'h01;
            MEM_SIZE_H: base_mask = 8'h03;
            MEM_SIZE_W: base_mask = 8'h0F;
            default:    base_mask = 8'hFF;
        endcase
    end

    assign wmask     = base_mask << offset;
    assign st_lanes  = st_data << {offset, 3'b000};
    assign ld_shift  = ld_raw >> {offset, 3'b000};
    assign ld_result = extend(ld_shift, size, zext);

endmodule

// File: rtl/mem_stage.sv
// Load/store stage: issues one RAM transaction per instruction at the active
// counter value and stalls the counter via mem_busy until it completes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [7:0] ACTIVE_CYCLE = 8'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instcycle_cnt_val,
    input  logic [4:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    mem_stage_if.master       ram,
    output logic              mem_busy,
    output logic              rd_wen,
    output logic [DATA_W-1:0] rd_data,
    output logic              misalign
);

    mem_state_e        state, state_nxt;
    logic              served;
    logic              is_load, is_store, start, req;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [2:0]        funct3_q;
    logic              store_q;
    logic [7:0]        wmask_al;
    logic [DATA_W-1:0] wdata_al, ld_al;

    assign is_load  = (opcode_i == OPCODE_LB) && (funct3_i != 3'b111);
    assign is_store = (opcode_i == OPCODE_SB) && !funct3_i[2];
    assign start    = (instcycle_cnt_val == ACTIVE_CYCLE) && (state == MEM_IDLE)
                      && !served && (is_load || is_store);

    // served blocks a second issue while the counter still reads ACTIVE_CYCLE after DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MEM_IDLE;
            served <= 1'b0;
        end else begin
            state <= state_nxt;
            if (instcycle_cnt_val != ACTIVE_CYCLE)
                served <= 1'b0;
            else if (start)
                served <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            store_q  <= is_store;
        end
    end

    mem_align u_align (
        .size      (funct3_q[1:0]),
        .zext      (funct3_q[2]),
        .offset    (addr_q[2:0]),
        .st_data   (wdata_q),
        .ld_raw    (ram.ram_rdata),
        .wmask     (wmask_al),
        .st_lanes  (wdata_al),
        .ld_result (ld_al)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if ((state == MEM_REQ) && ram.ram_ack && !store_q)
            rd_data <= ld_al;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        rd_wen    = 1'b0;
        misalign  = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (start)
                    state_nxt = addr_misaligned(funct3_i[1:0], addr_i[2:0]) ? MEM_FAULT : MEM_REQ;
            end
            MEM_REQ: begin
                req = 1'b1;
                if (ram.ram_ack)
                    state_nxt = MEM_DONE;
            end
            MEM_DONE: begin
                rd_wen    = !store_q;
                state_nxt = MEM_IDLE;
            end
            MEM_FAULT: begin
                misalign  = 1'b1;
                state_nxt = MEM_IDLE;
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    // RAM outputs are gated by REQ so they read zero whenever no access is pending
    assign mem_busy      = start || (state == MEM_REQ);
    assign ram.ram_req   = req;
    assign ram.ram_we    = req && store_q;
    assign ram.ram_addr  = req ? {addr_q[DATA_W-1:3], 3'b000} : '0;
    assign ram.ram_wmask = (req && store_q) ? wmask_al : 8'h00;
    assign ram.ram_wdata = (req && store_q) ? wdata_al : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: stimulus pushes expected RAM
// requests, load results and faults; a monitor pops and compares them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cnt = 8'd0;
    logic [4:0]  opcode_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [63:0] addr_i = 64'd0;
    logic [63:0] wdata_i = 64'd0;
    logic        mem_busy, rd_wen, misalign;
    logic [63:0] rd_data;

    mem_stage_if ram ();

    mem_stage #(.ACTIVE_CYCLE(8'd5)) dut (
        .clk               (clk),
        .rst               (rst),
        .instcycle_cnt_val (cnt),
        .opcode_i          (opcode_i),
        .funct3_i          (funct3_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .ram               (ram),
        .mem_busy          (mem_busy),
        .rd_wen            (rd_wen),
        .rd_data           (rd_data),
        .misalign          (misalign)
    );

    always #5 clk = ~clk;

    localparam int K_REQ   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_FAULT = 2;
    localparam logic [4:0] OP_IMM = 5'b00100;

    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic        we;
        logic [7:0]  mask;
        logic [63:0] wdata;
        logic [63:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_rd = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%h required=0x%h @%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every presented output against the queue head.
    exp_t cur;
    logic req_prev = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            req_prev = 1'b0;
            last_rd  = 64'd0;
        end else begin
            if (ram.ram_req && !req_prev) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_REQ) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req addr=0x%h required=none", ram.ram_addr);
                    cur.addr = ram.ram_addr; cur.we = ram.ram_we;
                    cur.mask = ram.ram_wmask; cur.wdata = ram.ram_wdata;
                end else begin
                    cur = exp_q.pop_front();
                    chk("req_addr", ram.ram_addr, cur.addr);
                    chk("req_we", 64'(ram.ram_we), 64'(cur.we));
                    chk("req_wmask", 64'(ram.ram_wmask), 64'(cur.mask));
                    if (cur.we) chk("req_wdata", ram.ram_wdata, cur.wdata);
                end
            end else if (ram.ram_req) begin
                chk("stable_addr", ram.ram_addr, cur.addr);
                chk("stable_we", 64'(ram.ram_we), 64'(cur.we));
                chk("stable_wmask", 64'(ram.ram_wmask), 64'(cur.mask));
                if (cur.we) chk("stable_wdata", ram.ram_wdata, cur.wdata);
            end
            if (rd_wen) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_LOAD) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd_wen rd_data=0x%h required=none", rd_data);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rd_data", rd_data, cur.rd);
                    last_rd = cur.rd;
                end
            end else begin
                chk("rd_hold", rd_data, last_rd);
            end
            if (misalign) begin
                if (exp_q.size() == 0 || exp_q[0].kind != K_FAULT) begin
                    checks++; errors++;
                    $display("FAIL unexpected_misalign actual=1 required=0");
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            req_prev = ram.ram_req;
        end
    end

    // One instruction at counter value 5, with the reference model applied up front.
    task automatic do_access(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] rdv, input int delay);
        bit          ld, st, go, bad;
        int          nbytes, off;
        logic [63:0] keep, v, res;
        exp_t        e;
        ld     = (op == OPCODE_LB) && (f3 != 3'b111);
        st     = (op == OPCODE_SB) && (f3[2] == 1'b0);
        go     = ld || st;
        nbytes = 1 << f3[1:0];
        off    = int'(addr[2:0]);
        bad    = (addr & 64'(nbytes - 1)) != 64'd0;
        e      = '{default: '0};
        if (go && bad) begin
            e.kind = K_FAULT;
            exp_q.push_back(e);
        end else if (go) begin
            e.kind  = K_REQ;
            e.addr  = addr & ~64'h7;
            e.we    = st;
            e.mask  = st ? 8'(((1 << nbytes) - 1) << off) : 8'h00;
            e.wdata = wd << (8 * off);
            exp_q.push_back(e);
            if (ld) begin
                v    = rdv >> (8 * off);
                keep = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
                res  = v & keep;
                if (!f3[2] && nbytes < 8 && res[8 * nbytes - 1]) res = res | ~keep;
                e.kind = K_LOAD;
                e.rd   = res;
                exp_q.push_back(e);
            end
        end

        @(negedge clk);
        cnt = 8'd5; opcode_i = op; funct3_i = f3; addr_i = addr; wdata_i = wd;
        ram.ram_ack = 1'($urandom_range(0, 1));
        #1 chk("busy_start", 64'(mem_busy), 64'(go));
        @(negedge clk);
        addr_i  = {$urandom, $urandom};
        wdata_i = {$urandom, $urandom};
        if (go && !bad) begin
            for (int k = 0; k <= delay; k++) begin
                if (k > 0) @(negedge clk);
                ram.ram_ack   = (k == delay);
                ram.ram_rdata = (k == delay) ? rdv : {$urandom, $urandom};
                #1;
                chk("busy_req", 64'(mem_busy), 64'd1);
                chk("req_held", 64'(ram.ram_req), 64'd1);
            end
            @(negedge clk);
            ram.ram_ack   = 1'b0;
            ram.ram_rdata = {$urandom, $urandom};
            #1;
            chk("busy_done", 64'(mem_busy), 64'd0);
            chk("rd_wen_done", 64'(rd_wen), 64'(ld));
        end else begin
            #1;
            chk("req_none", 64'(ram.ram_req), 64'd0);
            chk("busy_none", 64'(mem_busy), 64'd0);
            chk("misalign_pulse", 64'(misalign), 64'(go && bad));
        end
        @(negedge clk);
        #1;
        chk("no_reissue_busy", 64'(mem_busy), 64'd0);
        chk("no_reissue_req", 64'(ram.ram_req), 64'd0);
        chk("misalign_low", 64'(misalign), 64'd0);
        ram.ram_ack = 1'b0;
        cnt = 8'd6;
        @(negedge clk);
        cnt = 8'd0;
    endtask

    task automatic reset_mid_req();
        exp_t e;
        e = '{default: '0};
        e.kind = K_REQ;
        e.addr = 64'h8000_0010;
        exp_q.push_back(e);
        @(negedge clk);
        cnt = 8'd5; opcode_i = OPCODE_LB; funct3_i = 3'b010; addr_i = 64'h8000_0010;
        ram.ram_ack = 1'b0;
        @(negedge clk);
        #1 chk("rst_pre_req", 64'(ram.ram_req), 64'd1);
        #1 rst = 1'b1; cnt = 8'd0;
        #1;
        chk("rst_req_async", 64'(ram.ram_req), 64'd0);
        chk("rst_busy", 64'(mem_busy), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ram.ram_ack = 1'b1;
        ram.ram_rdata = {$urandom, $urandom};
        @(negedge clk);
        ram.ram_ack = 1'b0;
        #1;
        chk("rst_no_rd_wen", 64'(rd_wen), 64'd0);
        chk("rst_no_req", 64'(ram.ram_req), 64'd0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [63:0] rnd_addr;
        ram.ram_ack   = 1'b0;
        ram.ram_rdata = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", 64'(ram.ram_req), 64'd0);
        chk("reset_we", 64'(ram.ram_we), 64'd0);
        chk("reset_addr", ram.ram_addr, 64'd0);
        chk("reset_wmask", 64'(ram.ram_wmask), 64'd0);
        chk("reset_wdata", ram.ram_wdata, 64'd0);
        chk("reset_busy", 64'(mem_busy), 64'd0);
        chk("reset_rd_wen", 64'(rd_wen), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_misalign", 64'(misalign), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_access(OPCODE_LB, 3'b011, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 0);
        do_access(OPCODE_LB, 3'b000, 64'h8000_0007, 64'd0, 64'h8000_0000_0000_0000, 0);
        do_access(OPCODE_LB, 3'b100, 64'h8000_0007, 64'd0, 64'h8000_0000_0000_0000, 1);
        do_access(OPCODE_SB, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 0);
        do_access(OPCODE_LB, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0);
        do_access(OPCODE_SB, 3'b011, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 64'd0, 3);
        reset_mid_req();
        do_access(OP_IMM, 3'b000, 64'h8000_0000, 64'd0, 64'd0, 0);
        do_access(OPCODE_LB, 3'b111, 64'h8000_0000, 64'd0, 64'd0, 0);
        do_access(OPCODE_SB, 3'b100, 64'h8000_0000, 64'd0, 64'd0, 0);
        do_access(OPCODE_LB, 3'b101, 64'h8000_0006, 64'd0, 64'hFFEE_DDCC_BBAA_9988, 2);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = OPCODE_LB;
                2, 3:    op = OPCODE_SB;
                default: op = OP_IMM;
            endcase
            rnd_addr = 64'h8000_0000 + 64'($urandom_range(0, 255));
            do_access(op, 3'($urandom_range(0, 7)), rnd_addr, {$urandom, $urandom},
                      {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
